div_16x8_seq: RTL and testbench



---
 rtl/div_16x8_seq_if.sv | 29 ++
 rtl/div_16x8_seq.sv | 93 +++++++++
 tb/tb_div_16x8_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_16x8_seq_if.sv
// div_16x8_seq_if: request/result handshake bundle for div_16x8_seq.
// REM is present only when DIV_REM_EN is defined.
interface div_16x8_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] P;
   logic [7:0]  B;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  Q;
`ifdef DIV_REM_EN
   logic [7:0]  REM;
`endif
   logic        ovf;
   modport master (
      output in_valid, P, B, out_ready,
      input  in_ready, out_valid, Q, ovf
`ifdef DIV_REM_EN
      , input REM
`endif
   );
   modport slave (
      input  in_valid, P, B, out_ready,
      output in_ready, out_valid, Q, ovf
`ifdef DIV_REM_EN
      , output REM
`endif
   );
endinterface

// File: rtl/div_16x8_seq.sv
// div_16x8_seq: one-bit-per-cycle restoring divider, 16-bit product / 8-bit operand -> 8-bit quotient.
// Define DIV_REM_EN to expose the remainder on REM.
module div_16x8_seq (
   input logic           clk,
   input logic           rst,
   div_16x8_seq_if.slave io
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t     state_q, state_d;
   logic [7:0] r_q, r_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] quo_q, quo_d;
   logic [7:0] b_q, b_d;
   logic [2:0] cnt_q, cnt_d;
   logic       ovf_q, ovf_d;
   logic       out_valid_q, out_valid_d;
   logic [8:0] t;
   logic       ge;
   // r_q < b_q always holds in RUN, so the trial difference fits back into 8 bits
   assign t = {r_q, sh_q[7]};
   assign ge = t >= {1'b0, b_q};
   always_comb begin
      state_d = state_q;
      r_d = r_q;
      sh_d = sh_q;
      quo_d = quo_q;
      b_d = b_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: if (io.in_valid) begin
            if (io.P[15:8] >= io.B) begin
               state_d = DONE;
               quo_d = 8'hFF;
               r_d = 8'hFF;
               ovf_d = 1'b1;
               out_valid_d = 1'b1;
            end else begin
               state_d = RUN;
               r_d = io.P[15:8];
               sh_d = io.P[7:0];
               quo_d = '0;
               b_d = io.B;
               cnt_d = '0;
               ovf_d = 1'b0;
            end
         end
         RUN: begin
            r_d = ge ? 8'(t - {1'b0, b_q}) : t[7:0];
            quo_d = {quo_q[6:0], ge};
            sh_d = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: if (io.out_ready) begin
            state_d = IDLE;
            out_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         r_q <= '0;
         sh_q <= '0;
         quo_q <= '0;
         b_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q <= r_d;
         sh_q <= sh_d;
         quo_q <= quo_d;
         b_q <= b_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   assign io.in_ready = state_q == IDLE;
   assign io.out_valid = out_valid_q;
   assign io.Q = quo_q;
   assign io.ovf = ovf_q;
`ifdef DIV_REM_EN
   assign io.REM = r_q;
`endif
endmodule

// File: tb/tb_div_16x8_seq.sv
// tb_div_16x8_seq: randomized bench for div_16x8_seq against an arithmetic division model.
// Works with and without DIV_REM_EN.
module tb_div_16x8_seq;
   logic clk;
   logic rst;
   int checks;
   int errors;
   logic        pending;
   logic [15:0] cur_p;
   logic [7:0]  cur_b;
   logic [7:0]  exp_q, exp_rem;
   logic        exp_ovf;

   div_16x8_seq_if io ();
   div_16x8_seq dut (.clk(clk), .rst(rst), .io(io.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Quotient must fit 8 bits and B must be nonzero; otherwise the all-ones overflow response
   function automatic void model(input logic [15:0] p, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] rm, output logic o);
      int pi, bi;
      pi = int'(p);
      bi = int'(b);
      if (bi == 0 || pi / bi > 255) begin
         q = 8'hFF;
         rm = 8'hFF;
         o = 1'b1;
      end else begin
         q = 8'(pi / bi);
         rm = 8'(pi % bi);
         o = 1'b0;
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic pin(input logic [15:0] p, input logic [7:0] b,
                      input logic [7:0] q, input logic [7:0] rm, input logic o);
      logic [7:0] mq, mr;
      logic mo;
      model(p, b, mq, mr, mo);
      chk("pin_q", {24'd0, mq}, {24'd0, q});
      chk("pin_rem", {24'd0, mr}, {24'd0, rm});
      chk("pin_ovf", {31'd0, mo}, {31'd0, o});
   endtask

   always @(negedge clk) begin
      if (!rst && io.out_valid) begin
         int prod;
         checks++;
         prod = int'(io.Q) * int'(cur_b);
         if (!pending) begin
            errors++;
            $display("FAIL spurious_valid out_valid=1 with no request outstanding");
         end else if (io.Q !== exp_q || io.ovf !== exp_ovf) begin
            errors++;
            $display("FAIL result P=%0d B=%0d got Q=%0d ovf=%0d want Q=%0d ovf=%0d",
                     cur_p, cur_b, io.Q, io.ovf, exp_q, exp_ovf);
         end else if (!io.ovf && (prod > int'(cur_p) || int'(cur_p) - prod >= int'(cur_b))) begin
            errors++;
            $display("FAIL invariant P=%0d B=%0d got Q=%0d", cur_p, cur_b, io.Q);
         end
`ifdef DIV_REM_EN
         else if (io.REM !== exp_rem) begin
            errors++;
            $display("FAIL remainder P=%0d B=%0d got REM=%0d want REM=%0d", cur_p, cur_b, io.REM, exp_rem);
         end
`endif
      end
   end

   task automatic noise();
      io.in_valid = 1'($urandom_range(0, 1));
      io.P = 16'($urandom);
      io.B = 8'($urandom);
   endtask

   task automatic txn(input logic [15:0] p, input logic [7:0] b, input int hold);
      int n;
      n = 0;
      while (!io.in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_req", {31'd0, io.in_ready}, 32'd1);
      cur_p = p;
      cur_b = b;
      model(p, b, exp_q, exp_rem, exp_ovf);
      pending = 1'b1;
      io.in_valid = 1'b1;
      io.P = p;
      io.B = b;
      @(negedge clk);
      io.in_valid = 1'b0;
      chk("in_ready_busy", {31'd0, io.in_ready}, 32'd0);
      n = 0;
      while (!io.out_valid && n < 20) begin
         noise();
         @(negedge clk);
         n++;
      end
      io.in_valid = 1'b0;
      chk("latency", n, exp_ovf ? 32'd0 : 32'd8);
      repeat (hold) begin
         noise();
         chk("in_ready_done", {31'd0, io.in_ready}, 32'd0);
         @(negedge clk);
      end
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;
      @(negedge clk);
      io.out_ready = 1'b0;
      pending = 1'b0;
      chk("in_ready_after_accept", {31'd0, io.in_ready}, 32'd1);
      chk("out_valid_after_accept", {31'd0, io.out_valid}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      pending = 1'b0;
      cur_p = '0;
      cur_b = '0;
      exp_q = '0;
      exp_rem = '0;
      exp_ovf = 1'b0;
      rst = 1'b1;
      io.in_valid = 1'b0;
      io.out_ready = 1'b0;
      io.P = '0;
      io.B = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
      chk("rst_q", {24'd0, io.Q}, 32'd0);
      chk("rst_ovf", {31'd0, io.ovf}, 32'd0);
`ifdef DIV_REM_EN
      chk("rst_rem", {24'd0, io.REM}, 32'd0);
`endif
      rst = 1'b0;
      pin(16'd3000, 8'd25, 8'd120, 8'd0, 1'b0);
      pin(16'hFE00, 8'hFF, 8'd254, 8'd254, 1'b0);
      pin(16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
      pin(16'h0005, 8'd0, 8'hFF, 8'hFF, 1'b1);
      pin(16'd100, 8'd7, 8'd14, 8'd2, 1'b0);
      pin(16'd255, 8'd1, 8'd255, 8'd0, 1'b0);
      @(negedge clk);
      txn(16'd3000, 8'd25, 0);
      txn(16'hFE00, 8'hFF, 0);
      txn(16'hFFFF, 8'hFF, 0);
      txn(16'h0005, 8'd0, 0);
      txn(16'd100, 8'd7, 5);
      // Abort a division in flight: no result may appear afterwards
      io.in_valid = 1'b1;
      io.P = 16'd40000;
      io.B = 8'd200;
      @(negedge clk);
      io.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      pending = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, io.out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, io.in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      txn(16'd255, 8'd1, 0);
      for (int i = 0; i < 1500; i++) begin
         logic [7:0] a, b;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(1, 255));
         txn(16'(a * b), b, $urandom_range(0, 2));
      end
      for (int i = 0; i < 800; i++)
         txn(16'($urandom), (i % 16 == 0) ? 8'd0 : 8'($urandom), $urandom_range(0, 2));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
